divisor_sequencial: RTL
=======================

// Module: divisor_sequencial
// PURPOSE
//  Sequential restoring divider: the inverse of the shift-add multiplier.
//  Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, producing one
//  quotient bit per clock, so it can undo a multiplier product.
//  Sits beside the multiplier in the datapath with the same start-request
//  style (Sy) and a registered result with a completion pulse.
// PARAMETERS
//  WIDTH  16  divisor/quotient/remainder width; dividend is 2*WIDTH bits
// PORTS
//  Clk         in   1        clock, rising edge
//  Reset       in   1        asynchronous, active-low reset
//  Dividendo   in   2*WIDTH  dividend, sampled only at the start edge
//  Divisor     in   WIDTH    divisor, sampled only at the start edge
//  Sy          in   1        start request; a 0->1 transition starts a division
//  Quociente   out  WIDTH    quotient, registered
//  Resto       out  WIDTH    remainder, registered
//  Busy        out  1        1 while a division is in progress
//  Done        out  1        one-cycle pulse when results are valid
//  Overflow    out  1        quotient does not fit in WIDTH bits, or Divisor==0
// BEHAVIOUR
//  Reset (Reset=0, any time, including mid-division):
//  - Quociente=0, Resto=0, Busy=0, Done=0, Overflow=0.
//  - FSM goes to IDLE, count=0, Sy edge register cleared to 0.
//  - A Sy held at 1 through reset release does not start a division.
//  Start detection:
//  - Sy_d is Sy registered each cycle.
//  - Start = Sy & ~Sy_d, sampled only in IDLE or DONE.
//  - Sy edges while Busy=1 are ignored, not queued.
//  FSM states: IDLE, CALC, DONE.
//  - IDLE/DONE + Start:
//    - Load A[WIDTH:0]={0,Dividendo[2W-1:W]}, Q=Dividendo[W-1:0],
//      D=Divisor, count=0.
//    - Clear Overflow.
//    - If Dividendo[2W-1:W] >= Divisor (covers Divisor==0): go to DONE,
//      Overflow=1. Quociente and Resto keep their previous values.
//    - Otherwise go to CALC, Busy=1.
//  - CALC, each cycle:
//    - {A,Q} <<= 1.
//    - T = A - {0,D} in WIDTH+1 bits.
//    - If T >= 0, A=T and Q[0]=1; else Q[0]=0.
//    - count++. After the WIDTH-th CALC cycle, go to DONE.
//  - DONE: Busy=0. Done=1 for exactly one cycle.
//    - Quociente=Q and Resto=A[W-1:0] are registered on entry to DONE.
//    - Without Start, go to IDLE next cycle.
//  - DONE + Start: a new division starts immediately (back-to-back).
//  Latency:
//  - Normal: Done is high in the cycle following WIDTH CALC cycles, i.e.
//    WIDTH+1 clocks after the start edge.
//  - Overflow: Done is high 1 clock after the start edge.
//  Outputs:
//  - Quociente, Resto and Overflow hold until the next start or reset.
//  - Operand inputs may change freely after the start edge.
//  Invariant: on a non-overflow completion,
//    Dividendo == Quociente*Divisor + Resto and Resto < Divisor.
// TESTING (WIDTH=16)
//  - Dividendo=100, Divisor=7, Sy pulse
//    -> Done at start+17, Quociente=14, Resto=2, Overflow=0.
//  - 0xFFFE0001 / 0xFFFF
//    -> Quociente=0xFFFF, Resto=0. Then 0x0000FFFF / 1 -> 0xFFFF r 0.
//  - 0x00010000 / 1 -> Overflow=1 and Done at start+1.
//    Divisor=0 (any dividend) -> Overflow=1.
//    Quociente and Resto unchanged in both cases.
//  - Sy held high 40 cycles -> exactly one Done.
//    Extra Sy edge at start+5 -> ignored, result unaffected.
//  - Reset=0 at start+8 -> all outputs 0 the same cycle.
//    After release, a new 100/7 gives the correct 14 r 2.
//  - Random 10k operand pairs vs. a reference model.
//    Includes back-to-back starts in the DONE cycle.
//    Check the invariant and the overflow rule.

Source files
------------

// File: rtl/divisor_sequencial.sv
// -----------------------------------------------------------------------------
// divisor_sequencial
//
// Sequential restoring divider. Divides a 2*WIDTH-bit dividend by a WIDTH-bit
// divisor and produces one quotient bit per clock. It is the counterpart of the
// shift-add multiplier: a product it generates can be divided back into its
// operands. The start handshake (rising edge on Sy) and the registered results
// with a one-cycle completion pulse match the multiplier.
//
// Ports
//   Clk        in   1        clock, rising edge
//   Reset      in   1        asynchronous, active-low reset
//   Dividendo  in   2*WIDTH  dividend, sampled only on the start edge
//   Divisor    in   WIDTH    divisor, sampled only on the start edge
//   Sy         in   1        start request; a 0->1 transition starts a division
//   Quociente  out  WIDTH    quotient, registered
//   Resto      out  WIDTH    remainder, registered
//   Busy       out  1        high while a division is in progress
//   Done       out  1        one-cycle pulse when the results are valid
//   Overflow   out  1        quotient does not fit in WIDTH bits, or Divisor==0
//
// Timing
//   Normal division : Busy for WIDTH cycles, then Done in the next cycle.
//   Overflow        : Done in the cycle right after the start edge; Quociente
//                     and Resto keep their previous values.
//   A new start may be issued in the Done cycle (back-to-back operation).
// -----------------------------------------------------------------------------
module divisor_sequencial #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [2*WIDTH-1:0]   Dividendo,
    input  logic [WIDTH-1:0]     Divisor,
    input  logic                 Sy,
    output logic [WIDTH-1:0]     Quociente,
    output logic [WIDTH-1:0]     Resto,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Overflow
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    // Partial remainder. It always stays below the divisor between steps, so
    // WIDTH bits are enough; the shifted-in bit lives in a_sh below.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;      // low dividend half, becomes the quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;  // divisor captured at the start edge
    logic [CntW-1:0]  count_q, count_d;

    logic             sy_prev_q;     // Sy delayed by one cycle for edge detect
    // Set once Sy has been seen low after reset; stops a Sy held high through
    // reset release from looking like a fresh rising edge.
    logic             sy_armed_q;

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic             start;
    logic             hi_ge_dvs;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] a_sub;
    logic             step_ok;
    logic [WIDTH-1:0] a_step;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        start     = Sy & ~sy_prev_q & sy_armed_q;

        // High half >= divisor means the quotient needs more than WIDTH bits;
        // this also catches a zero divisor.
        hi_ge_dvs = (Dividendo[2*WIDTH-1:WIDTH] >= Divisor);

        // One restoring step: shift {A,Q} left, try subtracting the divisor.
        a_sh      = {a_q, q_q[WIDTH-1]};
        step_ok   = (a_sh >= {1'b0, dvs_q});
        // When the subtraction succeeds the true result is below the divisor,
        // so the modulo-2^WIDTH difference is exact.
        a_sub     = a_sh[WIDTH-1:0] - dvs_q;
        a_step    = step_ok ? a_sub : a_sh[WIDTH-1:0];
        q_step    = {q_q[WIDTH-2:0], step_ok};
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
                if (start) begin
                    a_d     = Dividendo[2*WIDTH-1:WIDTH];
                    q_d     = Dividendo[WIDTH-1:0];
                    dvs_d   = Divisor;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (hi_ge_dvs) begin
                        // Results keep their old values; only the flag moves.
                        state_d = StDone;
                        ovf_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StCalc;
                        busy_d  = 1'b1;
                    end
                end
            end

            StCalc: begin
                a_d     = a_step;
                q_d     = q_step;
                count_d = count_q + CntW'(1);
                if (count_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = q_step;
                    rem_d   = a_step;
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            a_q        <= '0;
            q_q        <= '0;
            dvs_q      <= '0;
            count_q    <= '0;
            sy_prev_q  <= 1'b0;
            sy_armed_q <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            q_q        <= q_d;
            dvs_q      <= dvs_d;
            count_q    <= count_d;
            sy_prev_q  <= Sy;
            sy_armed_q <= sy_armed_q | ~Sy;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Quociente = quo_q;
    assign Resto     = rem_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Overflow  = ovf_q;

endmodule
